// File: rtl/multiple_instructions.sv
// Single-cycle RV32I integer-subset core: internal program memory, one instruction per clock.
// Define MULTIPLE_INSTRUCTIONS_SHIFT_EN to add SLLI/SRLI/SRAI and SLL/SRL/SRA.

module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] memory [0:31];

    // x0 is never written, so clearing it on reset keeps the array fully defined.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) memory[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            memory[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : memory[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : memory[raddr2];
endmodule

module single_instruction (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction
);
    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpReg = 7'b0110011;
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] result;
    logic        wr_en;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm    = {{20{instruction[31]}}, instruction[31:20]};

    reg_file reg_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en),
        .waddr  (rd),
        .wdata  (result),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    // Unsupported encodings leave wr_en low; pc advances regardless.
    always_comb begin
        wr_en  = 1'b0;
        result = '0;
        case (opcode)
            OpImm: begin
                case (funct3)
                    3'b000: begin wr_en = 1'b1; result = rs1_val + imm; end
                    3'b100: begin wr_en = 1'b1; result = rs1_val ^ imm; end
                    3'b110: begin wr_en = 1'b1; result = rs1_val | imm; end
                    3'b111: begin wr_en = 1'b1; result = rs1_val & imm; end
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
                    3'b001: begin
                        if (funct7 == F7Base) begin
                            wr_en  = 1'b1;
                            result = rs1_val << rs2;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7Base) begin
                            wr_en  = 1'b1;
                            result = rs1_val >> rs2;
                        end else if (funct7 == F7Alt) begin
                            wr_en  = 1'b1;
                            result = $unsigned($signed(rs1_val) >>> rs2);
                        end
                    end
`endif
                    default: ;
                endcase
            end
            OpReg: begin
                if (funct7 == F7Base) begin
                    case (funct3)
                        3'b000: begin wr_en = 1'b1; result = rs1_val + rs2_val; end
                        3'b100: begin wr_en = 1'b1; result = rs1_val ^ rs2_val; end
                        3'b110: begin wr_en = 1'b1; result = rs1_val | rs2_val; end
                        3'b111: begin wr_en = 1'b1; result = rs1_val & rs2_val; end
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
                        3'b001: begin wr_en = 1'b1; result = rs1_val << rs2_val[4:0]; end
                        3'b101: begin wr_en = 1'b1; result = rs1_val >> rs2_val[4:0]; end
`endif
                        default: ;
                    endcase
                end else if (funct7 == F7Alt) begin
                    case (funct3)
                        3'b000: begin wr_en = 1'b1; result = rs1_val - rs2_val; end
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
                        3'b101: begin
                            wr_en  = 1'b1;
                            result = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule

module multiple_instructions #(
    parameter int unsigned PROG_DEPTH = 64
) (
    input  logic clk,
    input  logic reset
);
    localparam int unsigned AW = $clog2(PROG_DEPTH);
    localparam logic [31:0] PcMask = 32'(PROG_DEPTH * 4 - 1);

    logic [31:0] program_memory [0:PROG_DEPTH-1];
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instruction;

    assign instruction = program_memory[pc[AW+1:2]];
    // Masking keeps pc inside the program window so it wraps to 0 after the last word.
    assign pc_next = (pc + 32'd4) & PcMask;

    always_ff @(posedge clk) begin
        if (!reset) pc <= '0;
        else        pc <= pc_next;
    end

    single_instruction single_instr (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction)
    );
endmodule

// File: tb/tb_multiple_instructions.sv
// Self-checking bench for multiple_instructions: directed program table, hand-written
// reset/wrap sequences, and random programs checked against a behavioural model.
module tb_multiple_instructions;
    localparam int unsigned Depth = 64;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    typedef struct {
        bit          first;
        logic [31:0] instr;
        int unsigned rd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_prog [Depth];
    logic [31:0] m_pc;

    multiple_instructions #(.PROG_DEPTH(Depth)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] op_imm(input logic [2:0] f3, input int unsigned rd,
                                           input int unsigned rs1, input int imm);
        logic [31:0] iv;
        iv = imm;
        return {iv[11:0], rs1[4:0], f3, rd[4:0], 7'h13};
    endfunction

    function automatic logic [31:0] op_reg(input logic [6:0] f7, input logic [2:0] f3,
                                           input int unsigned rd, input int unsigned rs1,
                                           input int unsigned rs2);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction

    task automatic add(input bit first, input logic [31:0] instr, input int unsigned rd,
                       input logic [31:0] exp, input string name);
        vec_t v;
        v.first = first; v.instr = instr; v.rd = rd; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_reg(input int unsigned r);
        return dut.single_instr.reg_mem.memory[r];
    endfunction

    task automatic fill_nop();
        for (int k = 0; k < Depth; k++) dut.program_memory[k] = 32'h0000007F;
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] acc;
        acc = '0;
        for (int r = 0; r < 32; r++) acc = acc | rd_reg(r);
        check(name, acc, 32'd0);
    endtask

    // Behavioural model: decode by field values and apply the instruction's meaning directly.
    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, imm, v;
        logic        wr;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  sh;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        wr  = 1'b0; v = '0;
        if (opc == 7'h13) begin
            if (f3 == 3'd0)      begin wr = 1'b1; v = a + imm; end
            else if (f3 == 3'd4) begin wr = 1'b1; v = a ^ imm; end
            else if (f3 == 3'd6) begin wr = 1'b1; v = a | imm; end
            else if (f3 == 3'd7) begin wr = 1'b1; v = a & imm; end
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
            else if (f3 == 3'd1 && f7 == 7'h00) begin wr = 1'b1; v = a << sh; end
            else if (f3 == 3'd5 && f7 == 7'h00) begin wr = 1'b1; v = a >> sh; end
            else if (f3 == 3'd5 && f7 == 7'h20) begin wr = 1'b1; v = 32'($signed(a) >>> sh); end
`endif
        end else if (opc == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0)      begin wr = 1'b1; v = a + b; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin wr = 1'b1; v = a - b; end
            else if (f7 == 7'h00 && f3 == 3'd4) begin wr = 1'b1; v = a ^ b; end
            else if (f7 == 7'h00 && f3 == 3'd6) begin wr = 1'b1; v = a | b; end
            else if (f7 == 7'h00 && f3 == 3'd7) begin wr = 1'b1; v = a & b; end
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
            else if (f7 == 7'h00 && f3 == 3'd1) begin wr = 1'b1; v = a << b[4:0]; end
            else if (f7 == 7'h00 && f3 == 3'd5) begin wr = 1'b1; v = a >> b[4:0]; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin wr = 1'b1; v = 32'($signed(a) >>> b[4:0]); end
`endif
        end
        if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = v;
        m_pc = (m_pc + 4) % (Depth * 4);
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned kind;
        int unsigned rd, rs1, rs2;
        logic [2:0]  f3_list [4];
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3_list[0] = 3'd0; f3_list[1] = 3'd4; f3_list[2] = 3'd6; f3_list[3] = 3'd7;
        kind = $urandom_range(0, 9);
        rd   = $urandom_range(0, 31);
        rs1  = $urandom_range(0, 31);
        rs2  = $urandom_range(0, 31);
        f3   = f3_list[$urandom_range(0, 3)];
        f7   = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (kind <= 3) return op_imm(f3, rd, rs1, int'($urandom));
        if (kind <= 6) return op_reg(f7, f3, rd, rs1, rs2);
        f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd1;
        if (kind == 7) return op_imm(f3, rd, rs1, int'({f7, rs2[4:0]}));
        if (kind == 8) return op_reg(f7, f3, rd, rs1, rs2);
        return $urandom;
    endfunction

    initial begin
        int i, n, step;
        logic [31:0] mismatch;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        fill_nop();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", dut.pc, 32'd0);
        check_all_zero("reset_regs");

        add(1, op_imm(3'd0, 5, 0, 120), 5, 32'd120, "A_addi120");
        add(0, op_imm(3'd0, 5, 0, 200), 5, 32'd200, "A_addi200");
        add(0, op_imm(3'd0, 5, 5, 2000), 5, 32'd2200, "A_addi2000");
        add(0, op_imm(3'd7, 5, 0, -1), 5, 32'd0, "A_andi");
        add(0, op_imm(3'd6, 5, 0, 10), 5, 32'd10, "A_ori");
        add(1, op_imm(3'd0, 29, 0, 2), 29, 32'd2, "B_x29");
        add(0, op_imm(3'd0, 31, 0, 5), 31, 32'd5, "B_x31");
        add(0, op_reg(7'h00, 3'd0, 5, 31, 29), 5, 32'd7, "B_add");
        add(0, op_reg(7'h20, 3'd0, 5, 31, 29), 5, 32'd3, "B_sub");
        add(1, op_imm(3'd0, 10, 0, 2047), 10, 32'd2047, "C_x10");
        add(0, op_imm(3'd0, 11, 0, 2047), 11, 32'd2047, "C_x11");
        add(0, op_reg(7'h20, 3'd0, 6, 11, 10), 6, 32'd0, "C_sub0");
        add(0, op_reg(7'h20, 3'd0, 7, 0, 10), 7, 32'hFFFFF801, "C_subneg");
        add(1, op_imm(3'd0, 0, 0, 5), 0, 32'd0, "D_x0");
        add(0, op_imm(3'd0, 1, 0, 9), 1, 32'd9, "D_x1");
        add(0, 32'h0000007F, 1, 32'd9, "D_badop");
        add(0, op_imm(3'd4, 2, 1, 32'hF0), 2, 32'hF9, "D_xori");
        add(0, op_reg(7'h00, 3'd6, 3, 1, 2), 3, 32'hF9, "D_or");
        add(0, op_reg(7'h00, 3'd7, 4, 1, 2), 4, 32'd9, "D_and");
        add(0, op_reg(7'h00, 3'd4, 4, 4, 2), 4, 32'hF0, "D_xor_oldrd");
        add(0, op_reg(7'h20, 3'd4, 1, 4, 2), 1, 32'd9, "D_badf7");
        add(1, op_imm(3'd0, 1, 0, -16), 1, 32'hFFFFFFF0, "E_x1");
`ifdef MULTIPLE_INSTRUCTIONS_SHIFT_EN
        add(0, op_imm(3'd5, 2, 1, 32'h402), 2, 32'hFFFFFFFC, "E_srai");
        add(0, op_imm(3'd1, 3, 1, 4), 3, 32'hFFFFFF00, "E_slli");
`else
        add(0, op_imm(3'd5, 2, 1, 32'h402), 2, 32'd0, "E_srai_off");
        add(0, op_imm(3'd1, 3, 1, 4), 3, 32'd0, "E_slli_off");
`endif

        i = 0;
        step = 0;
        while (i < tbl.size()) begin
            if (tbl[i].first) begin
                reset = 1'b0;
                fill_nop();
                n = 0;
                do begin
                    dut.program_memory[n] = tbl[i+n].instr;
                    n++;
                end while (i + n < tbl.size() && !tbl[i+n].first);
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                step = 0;
            end
            @(posedge clk);
            #1;
            step++;
            check(tbl[i].name, rd_reg(tbl[i].rd), tbl[i].exp);
            check({tbl[i].name, "_pc"}, dut.pc, 32'(4 * step));
            i++;
        end

        // Mid-program reset suppresses the in-flight write; a rewritten word 0 runs on release.
        reset = 1'b0;
        fill_nop();
        dut.program_memory[0] = op_imm(3'd0, 1, 0, 1);
        dut.program_memory[1] = op_imm(3'd0, 2, 0, 2);
        dut.program_memory[2] = op_imm(3'd0, 3, 0, 3);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_x2", rd_reg(2), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_pc", dut.pc, 32'd0);
        check_all_zero("mid_reset_regs");
        dut.program_memory[0] = op_imm(3'd0, 4, 0, 44);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rerun_x4", rd_reg(4), 32'd44);
        check("rerun_x1", rd_reg(1), 32'd0);
        check("rerun_pc", dut.pc, 32'd4);

        // Fetch wraps to word 0 past the last word.
        reset = 1'b0;
        for (int k = 0; k < Depth; k++) dut.program_memory[k] = op_imm(3'd0, 1, 1, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (Depth) @(posedge clk);
        #1;
        check("wrap_pc", dut.pc, 32'd0);
        check("wrap_x1", rd_reg(1), 32'(Depth));
        repeat (3) @(posedge clk);
        #1;
        check("wrap2_pc", dut.pc, 32'd12);
        check("wrap2_x1", rd_reg(1), 32'(Depth + 3));

        // Random programs against the model, running past the wrap point.
        for (int p = 0; p < 4; p++) begin
            reset = 1'b0;
            for (int k = 0; k < Depth; k++) begin
                m_prog[k] = rand_instr();
                dut.program_memory[k] = m_prog[k];
            end
            for (int r = 0; r < 32; r++) m_regs[r] = '0;
            m_pc = '0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < Depth + 16; c++) begin
                @(posedge clk);
                #1;
                model_exec(m_prog[m_pc / 4]);
                mismatch = '0;
                for (int r = 0; r < 32; r++) begin
                    if (rd_reg(r) !== m_regs[r]) mismatch = mismatch | (32'd1 << r);
                end
                check($sformatf("rand_p%0d_c%0d_regmask", p, c), mismatch, 32'd0);
                check($sformatf("rand_p%0d_c%0d_pc", p, c), dut.pc, m_pc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multiple_instructions.md
# multiple_instructions

Single-cycle RV32I integer-subset core executing one instruction per clock from an internal word-addressed program memory. It has no data-memory or bus interface. Architectural state (program memory, register file) is reached hierarchically by the bench. It is the top of the system-level integration tests and wraps the single-instruction datapath.

## Interface
- Parameter `PROG_DEPTH`, default 64: number of 32-bit words in `program_memory`; must be a power of two.
- Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- Port `reset`, input, 1 bit: reset is synchronous and active-low.
- No other ports.
- Hierarchical names are fixed:
  - `program_memory[0:PROG_DEPTH-1]`: 32-bit array, written by the bench.
  - `single_instr`: datapath instance.
  - `single_instr.reg_mem.memory[0:31]`: 32×32 register file.
  - `pc`: 32-bit program counter.
  - `instruction`: 32-bit current instruction.

## Operation
- Fetch: `instruction = program_memory[pc[log2(PROG_DEPTH)+1:2]]`, combinational.
- Decode fields follow standard RV32I: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], I-immediate[31:20] sign-extended to 32 bits.
- OP-IMM instructions (opcode 0010011):
  - ADDI (000): rd = rs1 + imm.
  - XORI (100): rd = rs1 ^ imm.
  - ORI (110): rd = rs1 | imm.
  - ANDI (111): rd = rs1 & imm.
- OP instructions (opcode 0110011):
  - funct3 000 with funct7 0000000: ADD, rd = rs1 + rs2.
  - funct3 000 with funct7 0100000: SUB, rd = rs1 − rs2.
  - funct3 100: XOR. funct3 110: OR. funct3 111: AND. Each requires funct7 0000000.
- Arithmetic is modulo 2^32; no overflow flag and no trap.
- Register x0 reads as 0. Writes to x0 are discarded.
- Register reads are combinational, so rs1 or rs2 equal to rd reads the old value.
- Any other opcode, funct3 or funct7 combination is a no-op: no register write, pc still advances.
- pc advances by 4 every cycle and wraps to 0 past the last word.
- The core has no branches, loads or stores.

## Timing
- While `reset`=0 at a rising edge:
  - pc ← 0.
  - All 32 registers ← 0.
  - `program_memory` is untouched.
- At the first rising edge with `reset`=1, `program_memory[0]` executes. Its result is visible in the register file immediately after that edge.
- Latency is one cycle per instruction. Result of instruction k is visible after the (k+1)th edge following reset release.
- Asserting reset mid-program takes effect at the next edge. Any in-flight instruction's write is suppressed.
- Reset has priority over a simultaneous write.
- `program_memory` may be rewritten by the bench during reset. New contents take effect from pc=0.

## Configuration
- Macro `MULTIPLE_INSTRUCTIONS_SHIFT_EN`.
- Defined: adds the shift instructions.
  - SLLI (001, funct7 0000000), SRLI (101, 0000000), SRAI (101, 0100000). Shift amount is instr[24:20].
  - SLL, SRL, SRA on OP with the same funct3/funct7 encodings. Shift amount is rs2[4:0].
- Undefined: these encodings are no-ops like any other unsupported encoding.

## Test plan
- Program ADDI x5,x0,120; ADDI x5,x0,200; ADDI x5,x5,2000; ANDI x5,x0,−1; ORI x5,x0,10 -> after edges 1–5 following reset release, x5 = 120, 200, 2200, 0, 10.
- Program ADDI x29,x0,2; ADDI x31,x0,5; ADD x5,x31,x29; SUB x5,x31,x29 -> x29=2, x31=5, then x5=7, then x5=3.
- Program ADDI x10,x0,2047; ADDI x11,x0,2047; SUB x6,x11,x10 -> x6=0 after the 3rd edge. SUB x7,x0,x10 -> x7=0xFFFFF801.
- Reset and register rules:
  - Assert reset mid-program -> pc=0 and all registers 0 after the edge.
  - Release -> instruction 0 re-executes.
  - ADDI x0,x0,5 -> x0 stays 0.
- Robustness:
  - Unsupported opcode 0x7F word -> no register changes, pc+4.
  - pc runs past word `PROG_DEPTH`−1 -> fetch wraps to word 0.
- With `MULTIPLE_INSTRUCTIONS_SHIFT_EN`:
  - ADDI x1,x0,−16; SRAI x2,x1,2 -> x2=0xFFFFFFFC.
  - SLLI x3,x1,4 -> x3=0xFFFFFF00.
  - Without the macro, x2 and x3 stay 0.
